// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_wb_arbiter
//  Description : Schedules GPR writes onto the upper/lower writeback ports.
//                Fixed-latency pipe results own their port; NUM_REQ
//                variable-latency requesters fill idle ports round-robin.
//                Optional starvation guard enabled by WB_ARB_STARVE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  interlock,
   input  logic                  p_u_valid,
   input  logic [4:0]            p_u_rt,
   input  logic [31:0]           p_u_data,
   input  logic                  p_l_valid,
   input  logic [4:0]            p_l_rt,
   input  logic [31:0]           p_l_data,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*5-1:0]  req_rt,
   input  logic [NUM_REQ*32-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [31:0]           u_tdata,
   output logic [4:0]            u_rt,
   output logic                  u_rt_flag,
   output logic [31:0]           l_tdata,
   output logic [4:0]            l_rt,
   output logic                  l_rt_flag,
   output logic                  wb_stall
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SUM_W = PTR_W + 1;
   localparam logic [SUM_W-1:0] c_num_req = SUM_W'(NUM_REQ);

   // Unpacked views of the flattened requester buses
   logic [4:0]         req_rt_a   [NUM_REQ];
   logic [31:0]        req_data_a [NUM_REQ];

   logic               active;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_nxt;
   logic [PTR_W-1:0]   last_idx;
   logic [SUM_W-1:0]   last_sum;
   logic [SUM_W-1:0]   scan_sum;
   logic [PTR_W-1:0]   scan_idx;
   logic               any_grant;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] starved;
   logic               force_en;
   logic [PTR_W-1:0]   force_idx;
   logic               upper_free;
   logic               lower_free;
   logic               have_first;
   logic [4:0]         first_rt;

   logic               u_wr_nxt;
   logic [4:0]         u_rt_nxt;
   logic [31:0]        u_data_nxt;
   logic               l_wr_nxt;
   logic [4:0]         l_rt_nxt;
   logic [31:0]        l_data_nxt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_rt_a[gi]   = req_rt[5*gi +: 5];
         assign req_data_a[gi] = req_data[32*gi +: 32];
      end
   endgenerate

   // No grants and no state change while reset is held or the pipe is interlocked
   assign active    = ~interlock & ~rst;
   assign req_ready = grant;

   // Port ownership, eligibility filtering and round-robin scan for free ports
   always_comb begin
      grant      = '0;
      any_grant  = 1'b0;
      last_idx   = rr_ptr;
      scan_sum   = '0;
      scan_idx   = '0;
      force_en   = 1'b0;
      force_idx  = '0;
      upper_free = 1'b0;
      lower_free = 1'b0;
      have_first = 1'b0;
      first_rt   = '0;
      u_wr_nxt   = 1'b0;
      u_rt_nxt   = u_rt;
      u_data_nxt = u_tdata;
      l_wr_nxt   = 1'b0;
      l_rt_nxt   = l_rt;
      l_data_nxt = l_tdata;

      if (active) begin
         // Downward scan so the lowest starved index wins
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (starved[i]) begin
               force_en  = 1'b1;
               force_idx = PTR_W'(i);
            end
         end

         if (force_en) begin
            // Starved requester takes the upper port; pipe slots are bubbled
            grant[force_idx] = 1'b1;
            any_grant        = 1'b1;
            last_idx         = force_idx;
            have_first       = 1'b1;
            first_rt         = req_rt_a[force_idx];
            u_wr_nxt         = 1'b1;
            u_rt_nxt         = req_rt_a[force_idx];
            u_data_nxt       = req_data_a[force_idx];
            lower_free       = 1'b1;
         end else begin
            // Equal destinations: the lower slot is younger, so upper is dropped
            u_wr_nxt   = p_u_valid & ~(p_l_valid & (p_u_rt == p_l_rt));
            l_wr_nxt   = p_l_valid;
            if (u_wr_nxt) begin
               u_rt_nxt   = p_u_rt;
               u_data_nxt = p_u_data;
            end
            if (l_wr_nxt) begin
               l_rt_nxt   = p_l_rt;
               l_data_nxt = p_l_data;
            end
            upper_free = ~p_u_valid;
            lower_free = ~p_l_valid;
         end

         for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (scan_sum >= c_num_req) begin
               scan_sum = scan_sum - c_num_req;
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (req_valid[scan_idx] && !grant[scan_idx] && (upper_free || lower_free)
                && !(have_first && (req_rt_a[scan_idx] == first_rt))
                && !(!force_en && p_u_valid && (req_rt_a[scan_idx] == p_u_rt))
                && !(!force_en && p_l_valid && (req_rt_a[scan_idx] == p_l_rt))) begin
               grant[scan_idx] = 1'b1;
               any_grant       = 1'b1;
               last_idx        = scan_idx;
               have_first      = 1'b1;
               first_rt        = req_rt_a[scan_idx];
               if (upper_free) begin
                  upper_free = 1'b0;
                  u_wr_nxt   = 1'b1;
                  u_rt_nxt   = req_rt_a[scan_idx];
                  u_data_nxt = req_data_a[scan_idx];
               end else begin
                  lower_free = 1'b0;
                  l_wr_nxt   = 1'b1;
                  l_rt_nxt   = req_rt_a[scan_idx];
                  l_data_nxt = req_data_a[scan_idx];
               end
            end
         end
      end
   end

   // Pointer moves one past the last requester granted this cycle
   assign last_sum = {1'b0, last_idx} + SUM_W'(1);
   assign rr_nxt   = (last_sum >= c_num_req) ? '0 : last_sum[PTR_W-1:0];

   // Registered write ports and round-robin pointer; interlock freezes everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         u_rt_flag <= 1'b0;
         u_rt      <= '0;
         u_tdata   <= '0;
         l_rt_flag <= 1'b0;
         l_rt      <= '0;
         l_tdata   <= '0;
         rr_ptr    <= '0;
      end else if (!interlock) begin
         u_rt_flag <= u_wr_nxt;
         u_rt      <= u_rt_nxt;
         u_tdata   <= u_data_nxt;
         l_rt_flag <= l_wr_nxt;
         l_rt      <= l_rt_nxt;
         l_tdata   <= l_data_nxt;
         if (any_grant) begin
            rr_ptr <= rr_nxt;
         end
      end
   end

`ifdef WB_ARB_STARVE_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] wait_cnt [NUM_REQ];
   logic [CNT_W-1:0] wait_nxt [NUM_REQ];
   logic             stall_nxt;
   logic             stall_q;

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_starve
         assign starved[gi]  = req_valid[gi] & (wait_cnt[gi] >= c_limit);
         assign wait_nxt[gi] = (!req_valid[gi] || grant[gi]) ? '0 :
                               (wait_cnt[gi] < c_limit) ? wait_cnt[gi] + CNT_W'(1) :
                               wait_cnt[gi];

         // Per-requester wait counter, held during interlock
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wait_cnt[gi] <= '0;
            end else if (!interlock) begin
               wait_cnt[gi] <= wait_nxt[gi];
            end
         end
      end
   endgenerate

   // Stall is raised in the cycle a counter sits at the limit
   always_comb begin
      stall_nxt = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wait_nxt[i] >= c_limit) begin
            stall_nxt = 1'b1;
         end
      end
   end

   // Registered stall flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 1'b0;
      end else if (!interlock) begin
         stall_q <= stall_nxt;
      end
   end

   assign wb_stall = stall_q;
`else
   localparam int unused_starve_limit = STARVE_LIMIT;

   assign starved  = '0;
   assign wb_stall = 1'b0;
`endif

endmodule
`default_nettype wire
